// File: rtl/riscy_fetch_unit_if.sv
// ROM read port between the riscy fetch unit (master) and the program ROM (slave).
// rd rises with addr already stable; rd holds until ack is seen high while rd=1; data is valid only in that ack cycle.
interface riscy_fetch_unit_if #(
  parameter int DW = 8,
  parameter int AW = 4
) ();
  logic [AW-1:0] addr;
  logic          rd;
  logic [DW-1:0] data;
  logic          ack;

  modport master (output addr, output rd, input data, input ack);
  modport slave  (input addr, input rd, output data, output ack);
endinterface

// File: rtl/riscy_fetch_unit.sv
// riscy instruction fetch: PC, ROM read over req/ack, IR split into opcode/i_flag/inst_addr.
// Define RISCY_FETCH_INDIRECT_EN to build the IND state (second ROM read resolving i_flag=1 operands).
module riscy_fetch_unit #(
  parameter int DW       = 8,
  parameter int OPW      = 3,
  parameter int AW       = 4,
  parameter int RESET_PC = 0,
  parameter int TMO      = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic               ld_pc,
  input  logic [AW-1:0]      pc_in,
  input  logic               skip,
  riscy_fetch_unit_if.master rom,
  output logic [OPW-1:0]     opcode,
  output logic               i_flag,
  output logic [AW-1:0]      inst_addr,
  output logic [AW-1:0]      pc,
  output logic               inst_valid,
  output logic               busy,
  output logic               fetch_err,
  output logic [1:0]         fsm_state
);

`ifdef RISCY_FETCH_INDIRECT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_IND = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t        state, next_state;
  logic [DW-1:0] ir;
  logic [DW-1:0] data_q;
  logic          ack_q;
  logic          rom_rd_q;
  logic [AW-1:0] rom_addr_q;
  logic [7:0]    wait_cnt;
  logic          err_q;

  logic          start_rd;
  logic [AW-1:0] rd_addr;
  logic          cap_ir;
  logic          cap_ea;
  logic          tmo_hit;
  logic          pc_inc;
  logic          pc_load;
  logic          tmo_reached;

  // ROM data is registered on ack, so the FSM consumes it one cycle after the ack edge.
  assign tmo_reached = rom_rd_q && !rom.ack && (wait_cnt == 8'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_rd   = 1'b0;
    rd_addr    = rom_addr_q;
    cap_ir     = 1'b0;
    cap_ea     = 1'b0;
    tmo_hit    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ld_pc)     pc_load = 1'b1;
        else if (skip) pc_inc  = 1'b1;
        if (fetch_req && !err_q) begin
          next_state = S_FETCH;
          start_rd   = 1'b1;
          if (ld_pc)     rd_addr = pc_in;
          else if (skip) rd_addr = pc + AW'(1);
          else           rd_addr = pc;
        end
      end
      S_FETCH: begin
        if (ack_q) begin
          cap_ir = 1'b1;
          pc_inc = 1'b1;
`ifdef RISCY_FETCH_INDIRECT_EN
          if (data_q[AW]) begin
            next_state = S_IND;
            start_rd   = 1'b1;
            rd_addr    = data_q[AW-1:0];
          end else begin
            next_state = S_DONE;
          end
`else
          next_state = S_DONE;
`endif
        end else if (tmo_reached) begin
          tmo_hit    = 1'b1;
          next_state = S_IDLE;
        end
      end
`ifdef RISCY_FETCH_INDIRECT_EN
      S_IND: begin
        if (ack_q) begin
          cap_ea     = 1'b1;
          next_state = S_DONE;
        end else if (tmo_reached) begin
          tmo_hit    = 1'b1;
          next_state = S_IDLE;
        end
      end
`endif
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

`ifdef RISCY_FETCH_INDIRECT_EN
  logic [AW-1:0] ea;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= AW'(RESET_PC);
      ir         <= '0;
      data_q     <= '0;
      ack_q      <= 1'b0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      wait_cnt   <= '0;
      err_q      <= 1'b0;
`ifdef RISCY_FETCH_INDIRECT_EN
      ea         <= '0;
`endif
    end else begin
      ack_q <= rom_rd_q && rom.ack;
      if (rom_rd_q && rom.ack) data_q <= rom.data;

      if (start_rd) begin
        rom_rd_q   <= 1'b1;
        rom_addr_q <= rd_addr;
        wait_cnt   <= '0;
      end else if (rom_rd_q && rom.ack) begin
        rom_rd_q <= 1'b0;
      end else if (tmo_hit) begin
        rom_rd_q <= 1'b0;
        err_q    <= 1'b1;
      end else if (rom_rd_q) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (pc_load)     pc <= pc_in;
      else if (pc_inc) pc <= pc + AW'(1);

      if (cap_ir) ir <= data_q;
`ifdef RISCY_FETCH_INDIRECT_EN
      if (cap_ir)      ea <= data_q[AW-1:0];
      else if (cap_ea) ea <= data_q[AW-1:0];
`endif
    end
  end

`ifdef RISCY_FETCH_INDIRECT_EN
  assign inst_addr = ea;
`else
  assign inst_addr = ir[AW-1:0];
`endif

  assign opcode     = ir[DW-1 -: OPW];
  assign i_flag     = ir[AW];
  assign rom.rd     = rom_rd_q;
  assign rom.addr   = rom_addr_q;
  assign inst_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign fetch_err  = err_q;
  assign fsm_state  = state;

endmodule

// File: tb/tb_riscy_fetch_unit.sv
// Randomized scoreboard bench for riscy_fetch_unit; reference model works on the ROM array and a PC counter.
// Honours RISCY_FETCH_INDIRECT_EN the same way the design does.
module tb_riscy_fetch_unit;
  localparam int DW = 8;
  localparam int OPW = 3;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           fetch_req;
  logic           ld_pc;
  logic [AW-1:0]  pc_in;
  logic           skip;
  logic [OPW-1:0] opcode;
  logic           i_flag;
  logic [AW-1:0]  inst_addr;
  logic [AW-1:0]  pc;
  logic           inst_valid;
  logic           busy;
  logic           fetch_err;
  logic [1:0]     fsm_state;

  riscy_fetch_unit_if #(.DW(DW), .AW(AW)) rom_bus ();

  riscy_fetch_unit #(.DW(DW), .OPW(OPW), .AW(AW), .RESET_PC(0), .TMO(15)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .ld_pc(ld_pc), .pc_in(pc_in), .skip(skip),
    .rom(rom_bus), .opcode(opcode), .i_flag(i_flag), .inst_addr(inst_addr), .pc(pc),
    .inst_valid(inst_valid), .busy(busy), .fetch_err(fetch_err), .fsm_state(fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ROM model: ack after rom_wait cycles of rd, never when muted; force_ack drives ack regardless of rd
  logic [DW-1:0] rom_mem [16];
  int rom_wait = 0;
  bit rom_mute = 0;
  bit force_ack = 0;

  initial begin : rom_model
    int waited;
    waited = 0;
    rom_bus.ack = 1'b0;
    rom_bus.data = '0;
    forever begin
      @(posedge clk);
      #1;
      rom_bus.data = DW'($urandom);
      if (force_ack) begin
        rom_bus.ack = 1'b1;
      end else if (rom_bus.rd && !rom_mute) begin
        if (waited >= rom_wait) begin
          rom_bus.ack = 1'b1;
          rom_bus.data = rom_mem[rom_bus.addr];
          waited = 0;
        end else begin
          rom_bus.ack = 1'b0;
          waited++;
        end
      end else begin
        rom_bus.ack = 1'b0;
        waited = 0;
      end
    end
  end

  // scoreboards: {opcode, i_flag, inst_addr, pc} with expected cycle, and ROM read addresses
  logic [11:0]   exp_q[$];
  int            t_q[$];
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] mpc;

  logic rd_prev = 1'b0;
  always @(negedge clk) begin
    if (rom_bus.rd && !rd_prev) begin
      if (addr_q.size() == 0) check("unexpected_rom_read", 32'(rom_bus.addr), 32'hFFFF);
      else check("rom_read_addr", 32'(rom_bus.addr), 32'(addr_q.pop_front()));
    end
    rd_prev = rom_bus.rd;
    if (!rst && inst_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_inst_valid", 32'(inst_valid), 32'd0);
      end else begin
        check("inst_fields", 32'({opcode, i_flag, inst_addr, pc}), 32'(exp_q.pop_front()));
        check("inst_latency", 32'(cyc), 32'(t_q.pop_front()));
      end
    end
  end

  // driver: presents one fetch request for one cycle at a negedge and updates the model
  task automatic issue(input bit ld, input logic [AW-1:0] tgt, input bit sk, input bit expect_inst);
    logic [DW-1:0] word;
    logic [AW-1:0] ea;
    int t_exp;
    if (ld) mpc = tgt;
    else if (sk) mpc = mpc + 4'd1;
    word = rom_mem[mpc];
    addr_q.push_back(mpc);
    t_exp = cyc + 3 + rom_wait;
    ea = word[AW-1:0];
    if (expect_inst) begin
`ifdef RISCY_FETCH_INDIRECT_EN
      if (word[AW]) begin
        addr_q.push_back(word[AW-1:0]);
        ea = rom_mem[word[AW-1:0]][AW-1:0];
        t_exp = t_exp + 2 + rom_wait;
      end
`endif
      mpc = mpc + 4'd1;
      exp_q.push_back({word[DW-1 -: OPW], word[AW], ea, mpc});
      t_q.push_back(t_exp);
    end
    fetch_req = 1'b1;
    ld_pc = ld;
    pc_in = tgt;
    skip = sk;
    @(negedge clk);
    fetch_req = 1'b0;
    ld_pc = 1'b0;
    skip = 1'b0;
    check("rd_next_cycle", 32'(rom_bus.rd), 32'd1);
  endtask

  task automatic wait_idle(input bit disturb);
    int n;
    n = 0;
    while (busy && n < 200) begin
      if (disturb && $urandom_range(0, 2) == 0) begin
        fetch_req = 1'b1;
        ld_pc = 1'($urandom_range(0, 1));
        skip = 1'($urandom_range(0, 1));
        pc_in = AW'($urandom);
      end
      @(negedge clk);
      fetch_req = 1'b0;
      ld_pc = 1'b0;
      skip = 1'b0;
      n++;
    end
    check("idle_within_budget", 32'(n < 200), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mpc = '0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    fetch_req = 1'b0;
    ld_pc = 1'b0;
    skip = 1'b0;
    pc_in = '0;
    for (int i = 0; i < 16; i++) rom_mem[i] = DW'($urandom);
    rom_mem[0] = 8'hA3;
    rom_mem[2] = 8'h37;
    rom_mem[7] = 8'h0C;
    do_reset();

    check("reset_pc", 32'(pc), 32'd0);
    check("reset_rd", 32'(rom_bus.rd), 32'd0);
    check("reset_rom_addr", 32'(rom_bus.addr), 32'd0);
    check("reset_fields", 32'({opcode, i_flag, inst_addr}), 32'd0);
    check("reset_busy_err_valid", 32'({busy, fetch_err, inst_valid}), 32'd0);

    // A3 at address 0, zero-wait ROM
    rom_wait = 0;
    issue(0, '0, 0, 1);
    wait_idle(0);
    check("a3_opcode", 32'(opcode), 32'b101);
    check("a3_inst_addr", 32'(inst_addr), 32'h3);
    check("a3_pc", 32'(pc), 32'd1);

    // ld_pc beats skip when both present without a fetch
    ld_pc = 1'b1; pc_in = 4'h9; skip = 1'b1;
    @(negedge clk);
    ld_pc = 1'b0; skip = 1'b0;
    mpc = 4'h9;
    check("ld_beats_skip", 32'(pc), 32'h9);

    // PC wrap from 4'hF
    issue(1, 4'hF, 0, 1);
    wait_idle(0);
    check("pc_wrap", 32'(pc), 32'h0);

    // indirect candidate word 37 at address 2
    issue(1, 4'h2, 0, 1);
    wait_idle(0);
`ifdef RISCY_FETCH_INDIRECT_EN
    check("ind_inst_addr", 32'(inst_addr), 32'hC);
`else
    check("ind_inst_addr", 32'(inst_addr), 32'h7);
`endif
    check("ind_pc", 32'(pc), 32'h3);

    // skip with fetch, then disturbance while busy (ld_pc/skip/fetch_req ignored)
    issue(0, '0, 1, 1);
    wait_idle(0);
    rom_wait = 2;
    issue(0, '0, 0, 1);
    ld_pc = 1'b1; pc_in = 4'h5;
    @(negedge clk);
    ld_pc = 1'b0;
    wait_idle(1);
    check("ld_during_fetch_ignored", 32'(pc), 32'(mpc));

    // ROM never acks: timeout after 15 rd cycles
    rom_mute = 1;
    issue(0, '0, 0, 0);
    n = 1;
    while (rom_bus.rd && n < 40) begin
      @(negedge clk);
      if (rom_bus.rd) n++;
    end
    check("tmo_rd_cycles", 32'(n), 32'd15);
    check("tmo_err", 32'({fetch_err, busy}), 32'b10);
    check("tmo_pc_unchanged", 32'(pc), 32'(mpc));
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    check("err_blocks_fetch", 32'({busy, rom_bus.rd}), 32'd0);
    rom_mute = 0;
    do_reset();
    check("rst_clears_err", 32'(fetch_err), 32'd0);

    // reset mid-fetch: read aborted, late ack ignored
    rom_wait = 6;
    issue(0, '0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_drops_rd", 32'(rom_bus.rd), 32'd0);
    rst = 1'b0;
    mpc = '0;
    force_ack = 1;
    repeat (3) @(negedge clk);
    force_ack = 0;
    check("late_ack_ignored", 32'({busy, pc}), 32'd0);

    // randomized fetches
    for (int i = 0; i < 16; i++) rom_mem[i] = DW'($urandom);
    for (int it = 0; it < 40; it++) begin
      rom_wait = $urandom_range(0, 3);
      issue(1'($urandom_range(0, 3) == 0), AW'($urandom), 1'($urandom_range(0, 3) == 0), 1);
      wait_idle(1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("rand_pc", 32'(pc), 32'(mpc));
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
